// File: rtl/ir_line_emitter.sv
// ============================================================================
// Module   : ir_line_emitter
// Purpose  : Streams framed lines (header, payload from SPRAM banks, gap) onto
//            an 8-bit bus with a free-running pixel clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_line_emitter #(
  parameter int CLK_DIV    = 6,
  parameter int LINE_BYTES = 1024,
  parameter int GAP_BYTES  = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEn,
  input  logic [1:0]  iBank_Ready,
  output logic        oRd_Which,
  output logic [13:0] oRd_Addr,
  output logic        oRd_En,
  input  logic [15:0] iRd_Data,
  output logic        oIR_PCLK,
  output logic [7:0]  oIR_Data,
  output logic        oLine_Done,
  output logic [1:0]  oBank_Free,
  output logic        oBusy
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   SLOT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   HALF      = CW'(CLK_DIV / 2);
  localparam logic [15:0]     LAST_BYTE = 16'(LINE_BYTES - 1);
  localparam logic [13:0]     LAST_WORD = 14'(LINE_BYTES / 2 - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_BYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2, GAP = 2'd3} state_t;

  state_t        state;
  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] slot_nxt;
  logic [15:0]   byte_cnt;
  logic [1:0]    pending;
  logic [1:0]    clr;
  logic          next_bank;
  logic [15:0]   word;
  logic          rd_dly;
  logic          fetch;
  logic          line_end;

  always_comb begin
    slot_nxt = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
    // A word is fetched during the slot just before its high byte is shown.
    fetch    = ((state == HDR) && (byte_cnt == 16'd3)) ||
               ((state == PAY) && byte_cnt[0] && (byte_cnt != LAST_BYTE));
    line_end = (state == PAY) && (byte_cnt == LAST_BYTE) && (slot_cnt == SLOT_LAST);
    clr      = 2'b00;
    if (line_end) clr = next_bank ? 2'b10 : 2'b01;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      byte_cnt   <= '0;
      pending    <= 2'b00;
      next_bank  <= 1'b0;
      word       <= '0;
      rd_dly     <= 1'b0;
      oIR_PCLK   <= 1'b0;
      oIR_Data   <= 8'h00;
      oRd_Which  <= 1'b0;
      oRd_Addr   <= '0;
      oRd_En     <= 1'b0;
      oLine_Done <= 1'b0;
      oBank_Free <= 2'b00;
      oBusy      <= 1'b0;
    end else begin
      slot_cnt   <= slot_nxt;
      oIR_PCLK   <= (slot_nxt >= HALF);
      oRd_En     <= (slot_cnt == '0) && fetch;
      rd_dly     <= oRd_En;
      oLine_Done <= 1'b0;
      oBank_Free <= 2'b00;
      // A new ready pulse beats a clear landing on the same bit.
      pending    <= (pending & ~clr) | iBank_Ready;
      if (rd_dly) word <= iRd_Data;
      if (oRd_En) oRd_Addr <= (oRd_Addr == LAST_WORD) ? '0 : oRd_Addr + 14'd1;

      if (slot_cnt == SLOT_LAST) begin
        case (state)
          IDLE: begin
            if (iEn && pending[next_bank]) begin
              state     <= HDR;
              byte_cnt  <= '0;
              oIR_Data  <= 8'hFF;
              oBusy     <= 1'b1;
              oRd_Which <= next_bank;
              oRd_Addr  <= '0;
            end else begin
              oIR_Data  <= 8'h00;
            end
          end
          HDR: begin
            if (byte_cnt == 16'd3) begin
              state    <= PAY;
              byte_cnt <= '0;
              oIR_Data <= word[15:8];
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
              oIR_Data <= (byte_cnt == 16'd2) ? 8'h80 : 8'h00;
            end
          end
          PAY: begin
            if (byte_cnt == LAST_BYTE) begin
              state      <= GAP;
              byte_cnt   <= '0;
              oIR_Data   <= 8'h00;
              oLine_Done <= 1'b1;
              oBank_Free <= clr;
              next_bank  <= ~next_bank;
              oRd_Addr   <= '0;
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
              oIR_Data <= byte_cnt[0] ? word[15:8] : word[7:0];
            end
          end
          default: begin
            oIR_Data <= 8'h00;
            if (byte_cnt == GAP_LAST) begin
              state <= IDLE;
              oBusy <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 16'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ir_line_emitter.sv
// ============================================================================
// Module   : tb_ir_line_emitter
// Purpose  : Scoreboard bench for ir_line_emitter with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_line_emitter;

  localparam int DIV   = 6;
  localparam int LB    = 1024;
  localparam int WORDS = LB / 2;
  localparam int LTOT  = 4 + LB + 4;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEn  = 1'b0;
  logic [1:0]  iBank_Ready = 2'b00;
  logic [15:0] iRd_Data = 16'h0000;
  logic        oRd_Which;
  logic [13:0] oRd_Addr;
  logic        oRd_En;
  logic        oIR_PCLK;
  logic [7:0]  oIR_Data;
  logic        oLine_Done;
  logic [1:0]  oBank_Free;
  logic        oBusy;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic prev_pclk = 1'b0;

  logic [7:0]  exp_q[$];
  logic [14:0] rd_q[$];
  logic [1:0]  free_q[$];

  ir_line_emitter dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iBank_Ready(iBank_Ready),
    .oRd_Which(oRd_Which), .oRd_Addr(oRd_Addr), .oRd_En(oRd_En),
    .iRd_Data(iRd_Data), .oIR_PCLK(oIR_PCLK), .oIR_Data(oIR_Data),
    .oLine_Done(oLine_Done), .oBank_Free(oBank_Free), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  function automatic logic [15:0] memval(input logic bank, input logic [13:0] a);
    logic [7:0] k;
    k = a[7:0];
    if (!bank) return {k, ~k};
    return {k ^ 8'h5A, a[8:1]};
  endfunction

  // SPRAM bank model: one-cycle read latency
  always @(posedge iClk) begin
    if (oRd_En) iRd_Data <= memval(oRd_Which, oRd_Addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({oIR_PCLK, oIR_Data, oRd_Which, oRd_Addr, oRd_En, oLine_Done, oBank_Free, oBusy});
  endfunction

  task automatic push_line(input logic bank, output int start);
    logic [15:0] w;
    start = popped + exp_q.size();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    for (int k = 0; k < WORDS; k++) begin
      w = memval(bank, 14'(k));
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      rd_q.push_back({bank, 14'(k)});
    end
    for (int g = 0; g < 4; g++) exp_q.push_back(8'h00);
    free_q.push_back(bank ? 2'b10 : 2'b01);
  endtask

  task automatic pulse(input logic [1:0] b);
    iBank_Ready = b;
    @(negedge iClk);
    iBank_Ready = 2'b00;
  endtask

  task automatic wait_popped(input int target);
    int n;
    int budget;
    n = 0;
    budget = (target - popped) * (DIV + 1) + 200;
    while (popped < target && n < budget) begin
      @(negedge iClk);
      n++;
    end
    check("wait_bytes", 32'(popped >= target), 32'd1);
  endtask

  // Monitors: bus bytes at PCLK rise, read strobes, end-of-line pulses
  always @(negedge iClk) begin
    if (!prev_pclk && oIR_PCLK && oBusy) begin
      if (exp_q.size() == 0) begin
        check("byte_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        check("bus_byte", 32'(oIR_Data), 32'(exp_q.pop_front()));
        popped <= popped + 1;
      end
    end
    prev_pclk <= oIR_PCLK;
    if (oRd_En) begin
      if (rd_q.size() == 0) check("read_extra", 32'(rd_q.size()), 32'd1);
      else check("read_bank_addr", 32'({oRd_Which, oRd_Addr}), 32'(rd_q.pop_front()));
    end
    if (oLine_Done || oBank_Free != 2'b00) begin
      if (free_q.size() == 0) begin
        check("done_extra", 32'(free_q.size()), 32'd1);
      end else begin
        check("bank_free", 32'(oBank_Free), 32'(free_q.pop_front()));
        check("line_done", 32'(oLine_Done), 32'd1);
      end
    end
  end

  initial begin
    int s0, s1, s2, s3, s4, s5, s6, n;

    repeat (3) @(negedge iClk);
    check("reset_outputs", outs(), 32'd0);

    // Only bank 1 ready: must stay idle, PCLK keeps running
    iRst = 1'b0;
    iEn = 1'b1;
    iBank_Ready = 2'b10;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge iClk);
      if (k == 1) iBank_Ready = 2'b00;
      check("idle_pclk", 32'(oIR_PCLK), 32'((k % DIV) >= DIV / 2));
      check("idle_bus", 32'({oBusy, oIR_Data}), 32'd0);
    end
    repeat (20 * DIV) @(negedge iClk);
    check("idle_busy_bank1_only", 32'({oBusy, oIR_Data}), 32'd0);

    // Bank 0 then bank 1 back to back
    pulse(2'b01);
    push_line(1'b0, s0);
    wait_popped(s0 + 60);
    pulse(2'b10);
    push_line(1'b1, s1);
    wait_popped(s1 + LTOT);
    repeat (2 * DIV) @(negedge iClk);
    check("busy_after_two_lines", 32'(oBusy), 32'd0);

    // iEn dropped mid-line: line completes, pending bank 1 must wait
    pulse(2'b01);
    push_line(1'b0, s2);
    pulse(2'b10);
    wait_popped(s2 + 4 + 100);
    iEn = 1'b0;
    wait_popped(s2 + LTOT);
    repeat (50 * DIV) @(negedge iClk);
    check("hold_while_disabled", 32'(oBusy), 32'd0);
    check("queue_empty_disabled", 32'(exp_q.size()), 32'd0);

    // Re-enable: bank 1 line, then reset at payload byte 500
    iEn = 1'b1;
    push_line(1'b1, s3);
    wait_popped(s3 + 4 + 500);
    iRst = 1'b1;
    @(negedge iClk);
    check("midline_reset_outputs", outs(), 32'd0);
    exp_q.delete();
    rd_q.delete();
    free_q.delete();
    iRst = 1'b0;
    repeat (30 * DIV) @(negedge iClk);
    check("post_reset_idle", 32'({oBusy, oIR_Data}), 32'd0);

    // Bank 0 restart; bank 0 re-flagged on the very cycle its pending bit clears
    pulse(2'b01);
    push_line(1'b0, s4);
    wait_popped(s4 + 100);
    pulse(2'b10);
    push_line(1'b1, s5);
    wait_popped(s4 + 4 + LB - 1);
    n = 0;
    while (oIR_PCLK && n < 2 * DIV) begin
      @(negedge iClk);
      n++;
    end
    check("align_slot", 32'(oIR_PCLK), 32'd0);
    repeat (DIV - 1) @(negedge iClk);
    pulse(2'b01);
    push_line(1'b0, s6);
    wait_popped(s6 + LTOT);
    repeat (4 * DIV) @(negedge iClk);
    check("bytes_drained", 32'(exp_q.size()), 32'd0);
    check("reads_drained", 32'(rd_q.size()), 32'd0);
    check("frees_drained", 32'(free_q.size()), 32'd0);
    check("final_idle", 32'(oBusy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ir_line_emitter.md
IR_LINE_EMITTER -- requirements
Module: ir_line_emitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 6; main-clock cycles per output byte slot (even, >=4).
REQ-002 SHALL have parameter LINE_BYTES, default 1024; payload bytes per line (even, <=32768).
REQ-003 SHALL have parameter GAP_BYTES, default 4; idle byte slots after each line (>=1).
REQ-004 SHALL have port iClk, input, 1; the single clock, 66 MHz nominal.
REQ-005 SHALL have port iRst, input, 1; synchronous active-high reset.
REQ-006 SHALL have port iEn, input, 1; allows a new line to start.
REQ-007 SHALL have port iBank_Ready, input, 2; per-bank single-cycle pulse marking that SPRAM bank 0 or 1 holds a full line.
REQ-008 SHALL have port oRd_Which, output, 1; SPRAM bank being read.
REQ-009 SHALL have port oRd_Addr, output, 14; SPRAM word address.
REQ-010 SHALL have port oRd_En, output, 1; single-cycle read strobe.
REQ-011 SHALL have port iRd_Data, input, 16; SPRAM read data, valid 1 cycle after oRd_En.
REQ-012 SHALL have port oIR_PCLK, output, 1; emitted pixel clock.
REQ-013 SHALL have port oIR_Data, output, 8; emitted data bus.
REQ-014 SHALL have port oLine_Done, output, 1; 1-cycle pulse after the last payload byte slot ends.
REQ-015 SHALL have port oBank_Free, output, 2; 1-cycle pulse on the bit of the bank just emitted.
REQ-016 SHALL have port oBusy, output, 1; high in states HDR, PAY and GAP.

Function
REQ-017 SHALL run a slot counter 0..CLK_DIV-1 continuously, including in IDLE, so that the PCLK edges are always present.
REQ-018 SHALL drive oIR_PCLK low for slot counts 0..CLK_DIV/2-1 and high for the remaining counts, giving a rising edge mid-slot.
REQ-019 SHALL update oIR_Data only at slot count 0, holding it for the full slot.
REQ-020 SHALL latch iBank_Ready bits into pending[1:0]; if a set and a clear hit the same bit in one cycle, the set wins.
REQ-021 SHALL keep a next-bank pointer, starting at bank 0, which toggles after each completed line.
REQ-022 SHALL implement states IDLE, HDR, PAY and GAP, with all transitions taken at slot boundaries.
REQ-023 IDLE SHALL emit 0x00 and go to HDR when iEn=1 and pending[next]=1; otherwise it stays in IDLE.
REQ-024 HDR SHALL emit FF, 00, 00, 80 in four consecutive slots, then go to PAY.
REQ-025 PAY SHALL emit LINE_BYTES bytes from words at addresses 0..LINE_BYTES/2-1 of bank next, with the high byte [15:8] first and then the low byte [7:0].
REQ-026 SHALL prefetch each word by asserting oRd_En for one cycle at slot count 1 of the slot that precedes the word's high-byte slot.
  - For word 0, that preceding slot is the 0x80 header slot.
REQ-027 SHALL register iRd_Data on the cycle after oRd_En and drive it onto the bus at the next slot start.
REQ-028 SHALL hold oRd_Which constant for the whole line.
REQ-029 SHALL advance oRd_Addr after each read and return it to 0 at the end of the line, with no read issued past LINE_BYTES/2-1.
REQ-030 At the end of the last payload slot, SHALL do all of the following in the same cycle, then go to GAP:
  - pulse oLine_Done;
  - pulse oBank_Free[next];
  - clear pending[next];
  - toggle next.
REQ-031 GAP SHALL emit 0x00 for GAP_BYTES slots and then go to IDLE.
REQ-032 SHALL sample iEn only in IDLE; deasserting iEn during a line SHALL NOT truncate that line.
REQ-033 SHALL NOT serve bank 1 out of order: if only pending[1] is set while next=0, the block SHALL stay in IDLE.
REQ-034 SHALL ignore an iBank_Ready pulse for a bank that is already pending; no error is flagged.
REQ-035 SHALL hold the payload byte counter at 16 bits; payload ends when the count reaches LINE_BYTES-1 and is emitted.

Reset
REQ-036 While iRst=1 at a clock edge, the block SHALL take these values on the next cycle:
  - state=IDLE, slot count=0, pending=0, next=0;
  - oIR_PCLK=0, oIR_Data=0x00;
  - oRd_Which=0, oRd_Addr=0, oRd_En=0;
  - oLine_Done=0, oBank_Free=0, oBusy=0.
REQ-037 Reset asserted mid-line SHALL abort the line immediately, with no oLine_Done or oBank_Free pulse, and all pending requests lost.

Verification
REQ-038 Default parameters, iEn=1, iBank_Ready=01, bank 0 word k = {k[7:0], ~k[7:0]} -> sampled at PCLK rising edges: FF 00 00 80, then 00 FF 01 FE ... FF 00; then oLine_Done and oBank_Free=01 pulse once; oBusy drops after 4 idle 0x00 slots.
REQ-039 Pulse iBank_Ready=01 and then 10 during line 0 -> line 1 follows from bank 1 with oRd_Which=1; oBank_Free pulses 01 then 10; exactly 512 oRd_En pulses per line, addresses 0..511.
REQ-040 Only iBank_Ready=10 after reset -> oBusy stays 0 and the bus stays 0x00 with PCLK toggling every 3 cycles; a later 01 pulse -> bank 0 line, then bank 1 line.
REQ-041 iEn dropped at payload byte 100 -> full 1024-byte line completes; no new header follows while iEn=0 even with a pending bank.
REQ-042 iRst pulsed at payload byte 500 -> all outputs at reset values the next cycle; no oLine_Done; a new iBank_Ready=01 restarts from header at address 0.
REQ-043 iBank_Ready[0] pulsed in the same cycle pending[0] clears -> pending[0] stays set and a second bank-0 line is emitted.
